// File: rtl/morse_letter_decoder_pkg.sv
// morse_letter_decoder_pkg: symbol codes, ASCII constants and defaults shared by the Morse decoder.
package morse_letter_decoder_pkg;
  localparam logic [2:0] CODE_NONE  = 3'd0;
  localparam logic [2:0] CODE_DIT   = 3'd1;
  localparam logic [2:0] CODE_DAH   = 3'd2;
  localparam logic [2:0] CODE_GAP   = 3'd3;
  localparam logic [2:0] CODE_SPACE = 3'd4;
  localparam logic [7:0] ASCII_SPACE   = 8'h20;
  localparam logic [7:0] ASCII_UNKNOWN = 8'h3F;
  localparam int MAX_SYMS_DEFAULT = 6;
  function automatic logic is_symbol(input logic [2:0] code);
    return code == CODE_DIT || code == CODE_DAH;
  endfunction
endpackage

// File: rtl/morse_lut.sv
// morse_lut: {len,bits} -> ASCII, first symbol in bits[len-1], dah=1; digits need MORSE_DIGITS_EN.
module morse_lut
  import morse_letter_decoder_pkg::*;
(
  input  logic [2:0] len,
  input  logic [5:0] bits,
  output logic [7:0] ascii
);
  always_comb begin
    ascii = ASCII_UNKNOWN;
    case ({len, bits})
      {3'd1, 6'b000000}: ascii = 8'h45;
      {3'd1, 6'b000001}: ascii = 8'h54;
      {3'd2, 6'b000001}: ascii = 8'h41;
      {3'd2, 6'b000000}: ascii = 8'h49;
      {3'd2, 6'b000011}: ascii = 8'h4D;
      {3'd2, 6'b000010}: ascii = 8'h4E;
      {3'd3, 6'b000100}: ascii = 8'h44;
      {3'd3, 6'b000110}: ascii = 8'h47;
      {3'd3, 6'b000101}: ascii = 8'h4B;
      {3'd3, 6'b000111}: ascii = 8'h4F;
      {3'd3, 6'b000010}: ascii = 8'h52;
      {3'd3, 6'b000000}: ascii = 8'h53;
      {3'd3, 6'b000001}: ascii = 8'h55;
      {3'd3, 6'b000011}: ascii = 8'h57;
      {3'd4, 6'b001000}: ascii = 8'h42;
      {3'd4, 6'b001010}: ascii = 8'h43;
      {3'd4, 6'b000010}: ascii = 8'h46;
      {3'd4, 6'b000000}: ascii = 8'h48;
      {3'd4, 6'b000111}: ascii = 8'h4A;
      {3'd4, 6'b000100}: ascii = 8'h4C;
      {3'd4, 6'b000110}: ascii = 8'h50;
      {3'd4, 6'b001101}: ascii = 8'h51;
      {3'd4, 6'b000001}: ascii = 8'h56;
      {3'd4, 6'b001001}: ascii = 8'h58;
      {3'd4, 6'b001011}: ascii = 8'h59;
      {3'd4, 6'b001100}: ascii = 8'h5A;
`ifdef MORSE_DIGITS_EN
      {3'd5, 6'b011111}: ascii = 8'h30;
      {3'd5, 6'b001111}: ascii = 8'h31;
      {3'd5, 6'b000111}: ascii = 8'h32;
      {3'd5, 6'b000011}: ascii = 8'h33;
      {3'd5, 6'b000001}: ascii = 8'h34;
      {3'd5, 6'b000000}: ascii = 8'h35;
      {3'd5, 6'b010000}: ascii = 8'h36;
      {3'd5, 6'b011000}: ascii = 8'h37;
      {3'd5, 6'b011100}: ascii = 8'h38;
      {3'd5, 6'b011110}: ascii = 8'h39;
`else
`endif
      default: ascii = ASCII_UNKNOWN;
    endcase
  end
endmodule

// File: rtl/morse_letter_decoder.sv
// morse_letter_decoder: assembles dit/dah codes into ASCII letters and word spaces on a valid/ready port.
// Digit decoding is enabled by defining MORSE_DIGITS_EN (see morse_lut).
module morse_letter_decoder
  import morse_letter_decoder_pkg::*;
#(
  parameter int MAX_SYMS = MAX_SYMS_DEFAULT
) (
  input  logic       bigclk,
  input  logic       reset,
  input  logic [2:0] ditsdahs,
  input  logic       char_ready,
  output logic       char_valid,
  output logic [7:0] char_ascii,
  output logic       dropped
);
  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;
  localparam logic [2:0] MAX_LEN = 3'(MAX_SYMS);
  logic [0:0] state;
  logic [2:0] sym_len;
  logic [5:0] sym_bits;
  logic       ovf, sp_pend, sp_seen, last_sp;
  logic       sp_first, term, free, letter_load, space_load, sp_set;
  logic [7:0] lut_ascii;
  morse_lut u_lut (.len(sym_len), .bits(sym_bits), .ascii(lut_ascii));
  assign char_valid  = state == FULL;
  assign sp_first    = ditsdahs == CODE_SPACE && !sp_seen;
  assign term        = (ditsdahs == CODE_GAP || sp_first) && sym_len != 3'd0;
  assign free        = state == EMPTY || char_ready;
  // A pending word space owns the freed slot; a letter terminating then is lost.
  assign space_load  = sp_pend && free;
  assign letter_load = term && free && !sp_pend;
  assign sp_set      = sp_first && !sp_pend && (letter_load || !last_sp);
  always_ff @(posedge bigclk) begin
    if (reset) begin
      state      <= EMPTY;
      char_ascii <= 8'h00;
      dropped    <= 1'b0;
      sym_len    <= 3'd0;
      sym_bits   <= 6'd0;
      ovf        <= 1'b0;
      sp_pend    <= 1'b0;
      sp_seen    <= 1'b0;
      last_sp    <= 1'b0;
    end else begin
      if (ditsdahs <= CODE_SPACE) sp_seen <= ditsdahs == CODE_SPACE;
      if (term) begin
        sym_len  <= 3'd0;
        sym_bits <= 6'd0;
        ovf      <= 1'b0;
      end else if (is_symbol(ditsdahs)) begin
        sym_len  <= sym_len == MAX_LEN ? sym_len : sym_len + 3'd1;
        sym_bits <= {sym_bits[4:0], ditsdahs == CODE_DAH};
        ovf      <= ovf || sym_len == MAX_LEN;
      end
      if (term && !letter_load) dropped <= 1'b1;
      if (space_load) sp_pend <= 1'b0;
      else if (sp_set) sp_pend <= 1'b1;
      if (space_load || letter_load) begin
        state      <= FULL;
        char_ascii <= space_load ? ASCII_SPACE : (ovf ? ASCII_UNKNOWN : lut_ascii);
        last_sp    <= space_load;
      end else if (char_ready) begin
        state <= EMPTY;
      end
    end
  end
endmodule
